// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access-size codes, default depth.
// Pure declarations; no latency or backpressure of its own.
package lsu_pkg;

    localparam int LSU_DEPTH_LOG2 = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RSP  = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } lsu_size_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request, response and data-memory bus of the load/store unit.
// slave = lsu_ctrl, master = execute stage plus memory; no flow control beyond req_valid/req_ready.
interface lsu_ctrl_if #(
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;

    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_err, rsp_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_err, rsp_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata
    );

endinterface

// File: rtl/lsu_lane_merge.sv
// Sub-word lane logic: extracts and extends a load field, and merges store data into the old word.
// Combinational, zero latency; no backpressure. Only instantiated when LSU_SUBWORD_EN is defined.
module lsu_lane_merge
    import lsu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        offset,
    input  logic [1:0]        size,
    input  logic              sgn,
    output logic [DATA_W-1:0] ext_data,
    output logic [DATA_W-1:0] merged_data
);
    logic [5:0]        sh;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] lane_mask;

    always_comb begin
        sh        = {offset, 3'b000};
        shifted   = rdata >> sh;
        lane_mask = '1;
        ext_data  = shifted;
        case (size)
            SZ_B: begin
                lane_mask = {{(DATA_W-8){1'b0}}, 8'hFF};
                ext_data  = {{(DATA_W-8){sgn & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                lane_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
                ext_data  = {{(DATA_W-16){sgn & shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                lane_mask = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
                ext_data  = {{(DATA_W-32){sgn & shifted[31]}}, shifted[31:0]};
            end
            SZ_D: begin
                lane_mask = '1;
                ext_data  = shifted;
            end
            default: begin
                lane_mask = '1;
                ext_data  = shifted;
            end
        endcase
        merged_data = (rdata & ~(lane_mask << sh)) | ((wdata & lane_mask) << sh);
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit in front of a level-sensitive doubleword memory; sub-word access under LSU_SUBWORD_EN.
// Response 1 (error), 2 (load / dword store) or 3 (sub-word RMW) cycles after accept; req_ready low while busy, no rsp backpressure.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int DEPTH_LOG2 = LSU_DEPTH_LOG2
) (
    input  logic      clk,
    input  logic      reset,
    lsu_ctrl_if.slave bus
);
    lsu_state_e        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;

    logic              accept;
    logic [2:0]        align_mask;
    logic              misaligned;
    logic              out_of_range;
    logic              bad_size;
    logic              req_err;
    logic [DATA_W-1:0] load_data;

`ifdef LSU_SUBWORD_EN
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [2:0]        off_q, off_d;
    logic [DATA_W-1:0] merged_data;

    // mem_wdata_q still holds the raw store data during RD, so it feeds the merge directly.
    lsu_lane_merge #(.DATA_W(DATA_W)) u_lane_merge (
        .rdata      (bus.mem_rdata),
        .wdata      (mem_wdata_q),
        .offset     (off_q),
        .size       (size_q),
        .sgn        (sgn_q),
        .ext_data   (load_data),
        .merged_data(merged_data)
    );

    assign bad_size = 1'b0;
`else
    logic unused_signed;
    assign unused_signed = bus.req_signed;
    assign load_data     = bus.mem_rdata;
    assign bad_size      = (bus.req_size != SZ_D);
`endif

    assign accept       = bus.req_valid && req_ready_q;
    assign align_mask   = 3'(size_bytes(bus.req_size) - 4'd1);
    assign misaligned   = (bus.req_addr[2:0] & align_mask) != 3'd0;
    assign out_of_range = (bus.req_addr >> (3 + DEPTH_LOG2)) != '0;
    assign req_err      = misaligned || out_of_range || bad_size;

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
`ifdef LSU_SUBWORD_EN
        we_d   = we_q;
        size_d = size_q;
        sgn_d  = sgn_q;
        off_d  = off_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mem_addr_d  = bus.req_addr >> 3;
                    mem_wdata_d = bus.req_wdata;
`ifdef LSU_SUBWORD_EN
                    we_d   = bus.req_we;
                    size_d = bus.req_size;
                    sgn_d  = bus.req_signed;
                    off_d  = bus.req_addr[2:0];
`endif
                    if (req_err) begin
                        state_d   = ST_RSP;
                        rsp_err_d = 1'b1;
                    end else if (!bus.req_we) begin
                        state_d = ST_RD;
`ifdef LSU_SUBWORD_EN
                    end else if (bus.req_size != SZ_D) begin
                        state_d = ST_RD;
`endif
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_RD: begin
`ifdef LSU_SUBWORD_EN
                if (we_q) begin
                    state_d     = ST_WR;
                    mem_wdata_d = merged_data;
                end else begin
                    state_d     = ST_RSP;
                    rsp_rdata_d = load_data;
                end
`else
                state_d     = ST_RSP;
                rsp_rdata_d = load_data;
`endif
            end
            ST_WR:   state_d = ST_RSP;
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Strobes and handshakes are decoded from the next state so every output leaves a flop.
        req_ready_d = (state_d == ST_IDLE);
        mem_read_d  = (state_d == ST_RD);
        mem_write_d = (state_d == ST_WR);
        rsp_valid_d = (state_d == ST_RSP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
`ifdef LSU_SUBWORD_EN
            we_q   <= 1'b0;
            size_q <= SZ_D;
            sgn_q  <= 1'b0;
            off_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
`ifdef LSU_SUBWORD_EN
            we_q   <= we_d;
            size_q <= size_d;
            sgn_q  <= sgn_d;
            off_q  <= off_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit sitting directly upstream of the data memory; the execute stage issues LDUR/STUR-class requests into it.
- Accepts one request at a time on a valid/ready handshake.
- Converts the byte address to a doubleword index, checks alignment and range, and drives the memory's addr/idata/mreadsig/mwritesig strobes from registered outputs.
- Returns load data or completion as a single-cycle response.

Parameters:
- DATA_W, 64, data and byte-address width.
- DEPTH_LOG2, 5, log2 of memory depth in doublewords (32 entries).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; high only in IDLE.
- req_we  input  1  1=store, 0=load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 dword.
- req_signed  input  1  sign-extend sub-word loads.
- req_addr  input  64  byte address.
- req_wdata  input  64  store data; sub-word data in low bits.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_err  output  1  qualifies rsp_valid; misaligned, out-of-range or unsupported size.
- rsp_rdata  output  64  load result; 0 for stores and errors.
- mem_addr  output  64  doubleword index to memory.
- mem_wdata  output  64  write data to memory.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_rdata  input  64  memory read data, combinational from mem_addr.

Behaviour:
- Reset (async): state=IDLE; all outputs 0 except req_ready=1.
- Reset mid-operation forces IDLE and drops strobes immediately. An interrupted write leaves that memory word undefined. No response is issued.
- Accept occurs on the rising edge where req_valid && req_ready. The unit captures we, size, signed, wdata and index=req_addr>>3 (all outputs are registered).
- Error checks at accept:
  - Misaligned if req_addr[log2(bytes)-1:0] != 0.
  - Out of range if req_addr[63:3] >= 2**DEPTH_LOG2.
  - Size unsupported (see Optional Feature).
- States: IDLE, RD, WR, RSP.
  - IDLE, error request -> RSP with rsp_err=1. No strobes.
  - IDLE, load -> RD.
  - IDLE, dword store -> WR.
  - IDLE, sub-word store -> RD -> WR (read-modify-write).
  - RD: mem_read=1. mem_rdata is captured at the end of the cycle. -> RSP for loads, -> WR for RMW stores.
  - WR: mem_write=1 for exactly one cycle; mem_wdata = merged or full data. -> RSP.
  - RSP: rsp_valid=1 for one cycle. -> IDLE. req_ready returns high the next cycle.
- Response timing, counting cycles after the accept edge:
  - Load: rsp_valid in cycle 2.
  - Dword store: cycle 2.
  - Sub-word store: cycle 3.
  - Error: cycle 1.
- mem_addr holds the captured index from RD/WR entry until the next accept. It is never changed while mem_read or mem_write is high, because the memory is level-sensitive.
- mem_read and mem_write are never high together. Both are 0 in IDLE and RSP.
- Lane rule: little-endian; shift = req_addr[2:0]*8.
- Loads: the extracted field is zero-extended, or sign-extended when req_signed=1.
- No response backpressure: the consumer must take rsp_valid when it pulses.
- A new req_valid presented during a busy cycle is ignored; req_ready=0.

Optional Feature:
- Macro LSU_SUBWORD_EN.
- Defined: sizes 00/01/10 are supported, including sign/zero extension on loads and RD->WR merge for stores.
- Undefined: only size 11 is legal. Other sizes complete as error in 1 cycle. The RD->WR store path and the lane-merge logic are removed; stores always go IDLE->WR.

Decomposition:
- Package lsu_pkg:
  - State encoding (IDLE, RD, WR, RSP).
  - Size codes SZ_B/SZ_H/SZ_W/SZ_D.
  - DEPTH_LOG2 default.
  - Byte-count function.
- One sub-module, lsu_lane_merge (combinational):
  - Extract path: rdata, offset, size, signed -> result.
  - Merge path: old word, wdata, offset, size -> new word.
  - Instantiated only under LSU_SUBWORD_EN.

Test Plan:
- Reset asserted mid-RD -> state IDLE, mem_read=0 immediately. After release: req_ready=1, no rsp_valid.
- Load dword addr 0x50, memory[10]=1540 -> mem_read 1 cycle with mem_addr=10. rsp_valid in cycle 2 with rsp_rdata=1540, rsp_err=0.
- Store dword addr 0x58, wdata 0xDEAD -> one mem_write cycle, mem_addr=11, mem_wdata=0xDEAD. A following load of 0x58 returns 0xDEAD.
- Load size 11 addr 0x54 (misaligned) and addr 0x100 (index 32) -> rsp_valid in cycle 1, rsp_err=1, rsp_rdata=0, no strobes.
- LSU_SUBWORD_EN defined, memory[1]=100:
  - Store byte 0xAB to 0x0B -> RD then WR, memory[1]=0x00000000AB000064.
  - Signed byte load from 0x0B -> 0xFFFFFFFFFFFFFFAB.
  - Unsigned byte load -> 0xAB.
- LSU_SUBWORD_EN undefined: load size 00 addr 0x08 -> rsp_err=1 in cycle 1, no strobes.
